// File: rtl/synth_audio_pkg.sv
// ----------------------------------------------------------------------------
// synth_audio_pkg
// Shared constants for the synth_engine audio output path (clock generator and
// I2S serializer).
//   FRAME_BCLKS : BCLK periods per stereo frame
//   CH_BCLKS    : BCLK periods per channel (one LRCK half)
//   XFER_BIT    : bit_cnt value at which a new sample pair becomes active
//   stereo_t    : stereo pair at the default 24-bit width. Modules with a
//                 SAMPLE_W parameter declare the same layout at their own width.
// ----------------------------------------------------------------------------
package synth_audio_pkg;

    localparam int FRAME_BCLKS  = 64;
    localparam int CH_BCLKS     = 32;
    localparam int XFER_BIT     = 16;
    localparam int BIT_CNT_W    = $clog2(FRAME_BCLKS);
    localparam int SAMPLE_W_DEF = 24;

    typedef struct packed {
        logic signed [SAMPLE_W_DEF-1:0] left;
        logic signed [SAMPLE_W_DEF-1:0] right;
    } stereo_t;

endpackage

// File: rtl/audio_i2s_clkgen_if.sv
// ----------------------------------------------------------------------------
// audio_i2s_clkgen_if
// Sample handshake between the voice mixer (master) and audio_i2s_clkgen
// (slave).
//   i_valid      : sample pair valid (held by the producer until o_ready)
//   i_lsample    : left sample, signed
//   i_rsample    : right sample, signed
//   o_ready      : clkgen pending buffer is empty
//   o_sample_req : one-clk pulse per frame asking for the next pair
// ----------------------------------------------------------------------------
interface audio_i2s_clkgen_if #(
    parameter int SAMPLE_W = 24
);
    logic                       i_valid;
    logic signed [SAMPLE_W-1:0] i_lsample;
    logic signed [SAMPLE_W-1:0] i_rsample;
    logic                       o_ready;
    logic                       o_sample_req;

    modport master (
        output i_valid, i_lsample, i_rsample,
        input  o_ready, o_sample_req
    );

    modport slave (
        input  i_valid, i_lsample, i_rsample,
        output o_ready, o_sample_req
    );
endinterface

// File: rtl/audio_bclk_div.sv
// ----------------------------------------------------------------------------
// audio_bclk_div
// Divides the audio master clock into the I2S bit clock and frame clock and
// marks the per-frame sample transfer point.
//   clk         : audio master clock
//   reset_reg_N : async active-low reset
//   bclk        : bit clock, BCLK_DIV clks per period, 50% duty
//   lrck        : frame clock, 0 = left half, 1 = right half
//   xfer_stb    : one-clk strobe, high in the cycle before bit_cnt becomes
//                 XFER_BIT, so the consumer's registers update on that edge
// ----------------------------------------------------------------------------
module audio_bclk_div
    import synth_audio_pkg::*;
#(
    parameter int BCLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_reg_N,
    output logic bclk,
    output logic lrck,
    output logic xfer_stb
);
    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);

    logic [DIV_W-1:0]     div_cnt, div_nxt;
    logic [BIT_CNT_W-1:0] bit_cnt, bit_nxt;
    logic                 wrap;

    // NOTE: every always_comb output gets a default before any condition,
    // otherwise an unassigned path infers a latch.
    always_comb begin
        wrap    = (div_cnt == DIV_LAST);
        div_nxt = div_cnt + 1'b1;
        bit_nxt = bit_cnt;
        if (wrap) begin
            div_nxt = '0;
            bit_nxt = bit_cnt + 1'b1;
        end
    end

    assign xfer_stb = wrap && (bit_cnt == BIT_CNT_W'(XFER_BIT - 1));

    // BCLK and LRCK are decoded from the next-state counters so both edges
    // line up with div_cnt wrapping: BCLK falls and LRCK moves on the same clk.
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            bclk    <= 1'b0;
            lrck    <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            bit_cnt <= bit_nxt;
            bclk    <= (div_nxt >= DIV_HALF);
            lrck    <= bit_nxt[BIT_CNT_W-1];
        end
    end
endmodule

// File: rtl/audio_i2s_clkgen.sv
// ----------------------------------------------------------------------------
// audio_i2s_clkgen
// I2S clock generator and stereo sample double-buffer feeding the serializer.
//   clk            : audio master clock
//   reset_reg_N    : async active-low reset
//   bus            : slave side of the sample handshake (audio_i2s_clkgen_if)
//   oAUD_BCLK      : I2S bit clock
//   oAUD_DACLRCK   : frame clock, 0 = left, 1 = right
//   o_lsound_out   : active left word, changes only at the transfer point
//   o_rsound_out   : active right word, changes only at the transfer point
//   o_underrun_cnt : saturating count of frames with no pending pair
// Build option: define AUDIO_UNDERRUN_MUTE_EN to zero both active words on an
// underrun; by default the last active pair is repeated.
// ----------------------------------------------------------------------------
module audio_i2s_clkgen
    import synth_audio_pkg::*;
#(
    parameter int BCLK_DIV   = 4,
    parameter int SAMPLE_W   = 24,
    parameter int UNDERRUN_W = 16
) (
    input  logic                       clk,
    input  logic                       reset_reg_N,
    audio_i2s_clkgen_if.slave          bus,
    output logic                       oAUD_BCLK,
    output logic                       oAUD_DACLRCK,
    output logic signed [SAMPLE_W-1:0] o_lsound_out,
    output logic signed [SAMPLE_W-1:0] o_rsound_out,
    output logic [UNDERRUN_W-1:0]      o_underrun_cnt
);
    typedef struct packed {
        logic signed [SAMPLE_W-1:0] left;
        logic signed [SAMPLE_W-1:0] right;
    } pair_t;

    pair_t pending, active;
    logic  pending_full;
    logic  sample_req;
    logic  xfer_stb;
    logic  accept;

    audio_bclk_div #(.BCLK_DIV(BCLK_DIV)) u_bclk_div (
        .clk         (clk),
        .reset_reg_N (reset_reg_N),
        .bclk        (oAUD_BCLK),
        .lrck        (oAUD_DACLRCK),
        .xfer_stb    (xfer_stb)
    );

    assign accept           = bus.i_valid && !pending_full;
    assign bus.o_ready      = !pending_full;
    assign bus.o_sample_req = sample_req;
    assign o_lsound_out     = active.left;
    assign o_rsound_out     = active.right;

    // Accept and transfer never collide on a full buffer: accept needs it
    // empty, transfer only drains it when full. An accept during an underrun
    // transfer therefore lands in pending for the next frame.
    // NOTE: the sample buffers are reset along with the control state so the
    // serializer sees silence, not stale data, until the first real pair.
    always_ff @(posedge clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            pending        <= '0;
            active         <= '0;
            pending_full   <= 1'b0;
            sample_req     <= 1'b0;
            o_underrun_cnt <= '0;
        end else begin
            sample_req <= xfer_stb;

            if (accept) begin
                pending.left  <= bus.i_lsample;
                pending.right <= bus.i_rsample;
            end

            if (xfer_stb && pending_full) begin
                active       <= pending;
                pending_full <= 1'b0;
            end else begin
                if (accept) begin
                    pending_full <= 1'b1;
                end
                if (xfer_stb) begin
                    if (o_underrun_cnt != '1) begin
                        o_underrun_cnt <= o_underrun_cnt + 1'b1;
                    end
`ifdef AUDIO_UNDERRUN_MUTE_EN
                    active <= '0;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_audio_i2s_clkgen.sv
// ----------------------------------------------------------------------------
// tb_audio_i2s_clkgen
// Directed bench for audio_i2s_clkgen with BCLK_DIV=4, SAMPLE_W=24. A second
// instance with UNDERRUN_W=2 and no producer covers counter saturation.
// Accepted pairs are queued; each o_sample_req pops the queue (or models an
// underrun) and compares the active words and underrun count.
// Honours AUDIO_UNDERRUN_MUTE_EN in its expected values.
// ----------------------------------------------------------------------------
module tb_audio_i2s_clkgen;
    localparam int SW = 24;

    typedef struct packed {
        logic [SW-1:0] l;
        logic [SW-1:0] r;
    } pair_t;

    logic clk = 1'b0;
    logic reset_reg_N = 1'b0;
    always #5 clk = ~clk;

    audio_i2s_clkgen_if #(.SAMPLE_W(SW)) bus ();
    audio_i2s_clkgen_if #(.SAMPLE_W(SW)) bus2 ();

    logic          bclk, lrck, bclk2, lrck2;
    logic [SW-1:0] l_out, r_out, l_out2, r_out2;
    logic [15:0]   cnt;
    logic [1:0]    cnt2;

    audio_i2s_clkgen #(.BCLK_DIV(4), .SAMPLE_W(SW), .UNDERRUN_W(16)) dut (
        .clk            (clk),
        .reset_reg_N    (reset_reg_N),
        .bus            (bus),
        .oAUD_BCLK      (bclk),
        .oAUD_DACLRCK   (lrck),
        .o_lsound_out   (l_out),
        .o_rsound_out   (r_out),
        .o_underrun_cnt (cnt)
    );

    audio_i2s_clkgen #(.BCLK_DIV(4), .SAMPLE_W(SW), .UNDERRUN_W(2)) dut2 (
        .clk            (clk),
        .reset_reg_N    (reset_reg_N),
        .bus            (bus2),
        .oAUD_BCLK      (bclk2),
        .oAUD_DACLRCK   (lrck2),
        .o_lsound_out   (l_out2),
        .o_rsound_out   (r_out2),
        .o_underrun_cnt (cnt2)
    );

    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc = 0;
    int    req_at;
    pair_t sb_q[$];
    pair_t exp_act;
    int    exp_cnt;

    localparam pair_t P1 = '{l: 24'h123456, r: 24'hABCDEF};
    localparam pair_t P2 = '{l: 24'h7FFFFF, r: 24'h800000};
    localparam pair_t P3 = '{l: 24'h000001, r: 24'hFFFFFF};
    localparam pair_t P4 = '{l: 24'h5A5A5A, r: 24'hA5A5A5};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance to the next falling edge; cyc counts rising edges since release.
    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic drive(input pair_t p);
        bus.i_lsample = p.l;
        bus.i_rsample = p.r;
        bus.i_valid   = 1'b1;
    endtask

    // Scoreboard update for one transfer point, then compare.
    task automatic do_xfer(input string tag);
        if (sb_q.size() > 0) begin
            exp_act = sb_q.pop_front();
        end else begin
            exp_cnt++;
`ifdef AUDIO_UNDERRUN_MUTE_EN
            exp_act = '0;
`endif
        end
        check({tag, "_req"}, bus.o_sample_req, 1'b1);
        check({tag, "_l"}, l_out, exp_act.l);
        check({tag, "_r"}, r_out, exp_act.r);
        check({tag, "_cnt"}, cnt, exp_cnt[15:0]);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_bclk"}, bclk, 1'b0);
        check({tag, "_lrck"}, lrck, 1'b0);
        check({tag, "_ready"}, bus.o_ready, 1'b1);
        check({tag, "_req"}, bus.o_sample_req, 1'b0);
        check({tag, "_l"}, l_out, '0);
        check({tag, "_r"}, r_out, '0);
        check({tag, "_cnt"}, cnt, '0);
        check({tag, "_cnt2"}, cnt2, '0);
    endtask

    initial begin
        bus.i_valid = 1'b0;  bus.i_lsample = '0;  bus.i_rsample = '0;
        bus2.i_valid = 1'b0; bus2.i_lsample = '0; bus2.i_rsample = '0;
        exp_act = '0;
        exp_cnt = 0;

        #2;
        check_reset("rst0");
        repeat (3) @(negedge clk);
        reset_reg_N = 1'b1;
        cyc = 0;

        // BCLK: period 4, high in the second half.
        for (int k = 1; k <= 8; k++) begin
            step();
            check("bclk_phase", bclk, ((k % 4) >= 2));
        end

        // First pair before the first request.
        drive(P1);
        step();
        sb_q.push_back(P1);
        bus.i_valid = 1'b0;
        check("ready_after_accept", bus.o_ready, 1'b0);

        step_to(63);
        check("pre_xfer_req", bus.o_sample_req, 1'b0);
        check("pre_xfer_l", l_out, '0);
        check("pre_xfer_lrck", lrck, 1'b0);
        step();
        do_xfer("xfer1");
        step();
        check("req_one_clk", bus.o_sample_req, 1'b0);
        check("ready_after_xfer", bus.o_ready, 1'b1);

        // LRCK toggles every 128 clks.
        step_to(127); check("lrck_127", lrck, 1'b0);
        step();       check("lrck_128", lrck, 1'b1);
        step_to(255); check("lrck_255", lrck, 1'b1);
        step();       check("lrck_256", lrck, 1'b0);

        // Three silent frames: underruns.
        for (int f = 1; f <= 3; f++) begin
            step_to(64 + 256 * f - 1);
            check("underrun_pre_req", bus.o_sample_req, 1'b0);
            step();
            do_xfer("underrun");
            if (f == 1) check("sat_cnt2_two", cnt2, 2'd2);
        end
        check("underrun_total", cnt, 16'd3);

        // Accept coinciding with an underrun transfer.
        step_to(1087);
        drive(P2);
        step();
        do_xfer("simul");
        sb_q.push_back(P2);
        bus.i_valid = 1'b0;
        check("simul_ready", bus.o_ready, 1'b0);
        check("sat_cnt2_five", cnt2, 2'd3);
        step_to(1343);
        step();
        do_xfer("simul_next");

        // Pending full while the producer holds the next pair.
        step();
        drive(P3);
        step();
        sb_q.push_back(P3);
        drive(P4);
        step();
        check("full_ready", bus.o_ready, 1'b0);
        step_to(1599);
        check("full_ready_late", bus.o_ready, 1'b0);
        check("full_hold_l", l_out, P2.l);
        step();
        do_xfer("full_xfer");
        check("full_xfer_ready", bus.o_ready, 1'b1);
        sb_q.push_back(P4);
        step();
        check("held_accept", bus.o_ready, 1'b0);
        bus.i_valid = 1'b0;
        step_to(1855);
        step();
        do_xfer("held_xfer");

        // Reset mid-frame while bit_cnt = 40 (right half).
        step_to(1953);
        check("pre_reset_lrck", lrck, 1'b1);
        #2;
        reset_reg_N = 1'b0;
        #1;
        check_reset("rst_mid");
        sb_q.delete();
        exp_act = '0;
        exp_cnt = 0;
        @(negedge clk);
        reset_reg_N = 1'b1;
        cyc = 0;
        req_at = -1;
        for (int i = 0; i < 400; i++) begin
            step();
            if (bus.o_sample_req === 1'b1) begin
                req_at = cyc;
                break;
            end
        end
        check("req_after_reset", req_at, 64);
        if (req_at == 64) do_xfer("post_reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
